// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: PC-owning fetch front end; issues ROM reads, buffers {addr, inst} in a FIFO, hands them to decode via valid/ready, flushes on jump.
//   clk, rst (async, active-low)
//   jump_en_i/jump_addr_i: redirect; hold_flag_i: blocks pop only
//   rom_req_o/rom_addr_o/rom_inst_i: one-cycle-latency instruction ROM
//   inst_valid_o/inst_o/inst_addr_o/inst_ready_i: decode handshake; count_o: FIFO occupancy
module if_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      jump_en_i,
  input  logic [ADDR_W-1:0]         jump_addr_i,
  input  logic                      hold_flag_i,
  output logic                      rom_req_o,
  output logic [ADDR_W-1:0]         rom_addr_o,
  input  logic [31:0]               rom_inst_i,
  output logic                      inst_valid_o,
  output logic [31:0]               inst_o,
  output logic [ADDR_W-1:0]         inst_addr_o,
  input  logic                      inst_ready_i,
  output logic [$clog2(DEPTH):0]    count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH);
  logic [ADDR_W-1:0] pc, inflight_addr;
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [31:0] fifo_inst [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  logic inflight, kill, push, pop;
  // Reserve a slot for the outstanding read so a response never lands on a full FIFO.
  assign occ = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign rom_req_o = rst & ~jump_en_i & (occ < LIM);
  assign rom_addr_o = pc;
  assign push = inflight & ~kill & ~jump_en_i;
  assign pop = inst_valid_o & inst_ready_i & ~hold_flag_i & ~jump_en_i;
  assign inst_valid_o = count != '0;
  assign inst_o = inst_valid_o ? fifo_inst[rd_ptr] : NOP_INST;
  assign inst_addr_o = inst_valid_o ? fifo_addr[rd_ptr] : '0;
  assign count_o = count;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
      inflight_addr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      inflight <= 1'b0;
      kill <= 1'b0;
    end else if (jump_en_i) begin
      pc <= {jump_addr_i[ADDR_W-1:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      kill <= inflight;
      inflight <= 1'b0;
    end else begin
      if (rom_req_o) begin
        pc <= pc + ADDR_W'(4);
        inflight_addr <= pc;
        kill <= 1'b0;
      end
      inflight <= rom_req_o;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= inflight_addr;
      fifo_inst[wr_ptr] <= rom_inst_i;
    end
  end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed checks of reset, streaming, hold backpressure, jumps, PC wrap and async reset.
module tb_if_prefetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 0, rst = 0, jump_en = 0, hold = 0, ready = 0;
  logic [31:0] jump_addr = 0, rom_inst = 0;
  logic rom_req, inst_valid, w_req, w_valid;
  logic [31:0] rom_addr, inst, inst_addr, w_addr, w_inst, w_inst_addr;
  logic [2:0] count, w_count;
  int compared = 0, mismatched = 0;
  if_prefetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .jump_en_i(jump_en), .jump_addr_i(jump_addr), .hold_flag_i(hold),
    .rom_req_o(rom_req), .rom_addr_o(rom_addr), .rom_inst_i(rom_inst),
    .inst_valid_o(inst_valid), .inst_o(inst), .inst_addr_o(inst_addr),
    .inst_ready_i(ready), .count_o(count));
  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .jump_en_i(1'b0), .jump_addr_i(32'h0), .hold_flag_i(1'b0),
    .rom_req_o(w_req), .rom_addr_o(w_addr), .rom_inst_i(32'h0),
    .inst_valid_o(w_valid), .inst_o(w_inst), .inst_addr_o(w_inst_addr),
    .inst_ready_i(1'b1), .count_o(w_count));
  always #5 clk = ~clk;
  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  always @(posedge clk) if (rom_req) rom_inst <= f(rom_addr);
  always @(negedge clk) if (rst) begin
    compared++;
    assert (count <= 3'(DEPTH)) else begin
      mismatched++;
      $error("FAIL overflow: count %0d exceeds %0d", count, DEPTH);
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic restart(input logic rdy);
    rst = 0; jump_en = 0; hold = 0; jump_addr = 0; ready = rdy;
    cyc();
    rst = 1;
    #1;
  endtask
  initial begin
    restart(1);
    chk("c0 req", rom_req, 1); chk("c0 addr", rom_addr, 0); chk("c0 valid", inst_valid, 0);
    chk("c0 inst", inst, NOP); chk("c0 iaddr", inst_addr, 0); chk("c0 count", count, 0);
    chk("wrap c0 addr", w_addr, 32'hFFFF_FFFC);
    cyc(); #1;
    chk("c1 addr", rom_addr, 4); chk("c1 valid", inst_valid, 0); chk("wrap c1 addr", w_addr, 0);
    for (int c = 2; c < 7; c++) begin
      cyc(); #1;
      chk("stream valid", inst_valid, 1); chk("stream iaddr", inst_addr, 32'((c - 2) * 4));
      chk("stream inst", inst, f(32'((c - 2) * 4))); chk("stream count", count, 1);
    end
    restart(1);
    cyc(); #1;
    cyc(); hold = 1; #1;
    chk("h2 iaddr", inst_addr, 0); chk("h2 count", count, 1); chk("h2 addr", rom_addr, 8);
    cyc(); #1; chk("h3 count", count, 2); chk("h3 req", rom_req, 1);
    cyc(); #1; chk("h4 count", count, 3); chk("h4 req", rom_req, 0); chk("h4 pc", rom_addr, 32'h10);
    cyc(); #1; chk("h5 count", count, 4); chk("h5 req", rom_req, 0);
    cyc(); #1; chk("h6 count", count, 4); chk("h6 iaddr", inst_addr, 0);
    cyc(); hold = 0; #1; chk("h7 iaddr", inst_addr, 0); chk("h7 req", rom_req, 0);
    cyc(); #1; chk("h8 iaddr", inst_addr, 4); chk("h8 req", rom_req, 1); chk("h8 addr", rom_addr, 32'h10);
    for (int k = 0; k < 3; k++) begin
      cyc(); #1; chk("hold order", inst_addr, 32'(8 + 4 * k)); chk("hold valid", inst_valid, 1);
    end
    chk("h11 inst", inst, f(32'h10));
    restart(0);
    cyc(); #1;
    cyc(); #1;
    cyc(); jump_en = 1; jump_addr = 32'h100; #1;
    chk("j3 count", count, 2); chk("j3 req", rom_req, 0);
    cyc(); jump_en = 0; #1;
    chk("j4 count", count, 0); chk("j4 addr", rom_addr, 32'h100); chk("j4 req", rom_req, 1); chk("j4 valid", inst_valid, 0);
    cyc(); #1; chk("j5 count", count, 0); chk("j5 valid", inst_valid, 0);
    cyc(); #1; chk("j6 valid", inst_valid, 1); chk("j6 iaddr", inst_addr, 32'h100); chk("j6 inst", inst, f(32'h100));
    jump_en = 1; jump_addr = 32'h103;
    cyc(); jump_en = 0; #1; chk("align addr", rom_addr, 32'h100); chk("align count", count, 0);
    cyc(); jump_en = 1; jump_addr = 32'h200; #1; chk("jj0 req", rom_req, 0);
    cyc(); jump_addr = 32'h300; #1; chk("jj1 count", count, 0); chk("jj1 valid", inst_valid, 0);
    cyc(); jump_en = 0; #1; chk("jj2 addr", rom_addr, 32'h300); chk("jj2 valid", inst_valid, 0);
    cyc(); #1; chk("jj3 valid", inst_valid, 0); chk("jj3 count", count, 0);
    cyc(); #1; chk("jj4 valid", inst_valid, 1); chk("jj4 iaddr", inst_addr, 32'h300);
    ready = 1;
    cyc(); #1; chk("jj5 iaddr", inst_addr, 32'h304); chk("jj5 count", count, 1);
    cyc(); #1; chk("jj6 iaddr", inst_addr, 32'h308);
    restart(0);
    cyc(); #1;
    cyc(); #1;
    cyc(); #1;
    cyc(); #1; chk("r4 count", count, 3); chk("r4 req", rom_req, 0);
    rst = 0; #1;
    chk("ar req", rom_req, 0); chk("ar addr", rom_addr, 0); chk("ar valid", inst_valid, 0);
    chk("ar inst", inst, NOP); chk("ar iaddr", inst_addr, 0); chk("ar count", count, 0);
    cyc(); cyc(); rst = 1; #1;
    chk("rr0 req", rom_req, 1); chk("rr0 addr", rom_addr, 0);
    cyc(); cyc(); #1;
    chk("rr2 valid", inst_valid, 1); chk("rr2 iaddr", inst_addr, 0); chk("rr2 inst", inst, f(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
